serial_pattern_source: RTL and testbench

SERIAL_PATTERN_SOURCE -- requirements
Module: serial_pattern_source

---
 rtl/serial_pattern_source_pkg.sv | 23 ++
 rtl/serial_pattern_cnt.sv | 40 ++++
 rtl/serial_pattern_source.sv | 141 ++++++++++++++
 tb/tb_serial_pattern_source.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_source_pkg.sv
`default_nettype none
// ============================================================================
// serial_pattern_source_pkg : shared state type, defaults and length helper
// Rev 1.0
// ============================================================================
package serial_pattern_source_pkg;

   localparam int DEFAULT_WIDTH = 24;
   localparam int DEFAULT_LEN_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A requested length of 0 or beyond the register width means "whole register".
   function automatic int eff_len(input int len, input int width);
      return ((len == 0) || (len > width)) ? width : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_pattern_cnt.sv
`default_nettype none
// ============================================================================
// serial_pattern_cnt : bit-position counter, wraps to 0 after last_i
// Rev 1.0
// ============================================================================
module serial_pattern_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] last_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_o = (cnt_q == last_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_pattern_source.sv
`default_nettype none
// ============================================================================
// serial_pattern_source : MSB-first serialiser with one-shot and rotate modes
// Rev 1.0
// ============================================================================
module serial_pattern_source
   import serial_pattern_source_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN_W = DEFAULT_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   input  logic             mode,
   input  logic             stop,
   output logic             x,
   output logic             x_valid,
   output logic             sof,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [LEN_W-1:0] last_q, last_d;
   logic             mode_q, mode_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             sof_q, sof_d;
   logic             done_q, done_d;
   logic             load_ready_q, load_ready_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;

   serial_pattern_cnt #(
      .CNT_W (LEN_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .last_i (last_q),
      .tc_o   (cnt_tc)
   );

   // The bit on x is computed one cycle ahead; shift_q holds the bits still to go, MSB-aligned.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      shadow_d  = shadow_q;
      last_d    = last_q;
      mode_d    = mode_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      sof_d     = 1'b0;
      done_d    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               state_d   = ST_SEND;
               shift_d   = load_data << 1;
               shadow_d  = load_data;
               last_d    = LEN_W'(eff_len(int'(load_len), WIDTH) - 1);
               mode_d    = mode;
               x_d       = load_data[WIDTH-1];
               x_valid_d = 1'b1;
               sof_d     = 1'b1;
               cnt_clr   = 1'b1;
            end
         end
         ST_SEND: begin
            if (stop || (cnt_tc && !mode_q)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               cnt_clr = 1'b1;
            end else if (cnt_tc) begin
               shift_d   = shadow_q << 1;
               x_d       = shadow_q[WIDTH-1];
               x_valid_d = 1'b1;
               sof_d     = 1'b1;
               cnt_en    = 1'b1;
            end else begin
               shift_d   = shift_q << 1;
               x_d       = shift_q[WIDTH-1];
               x_valid_d = 1'b1;
               cnt_en    = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign load_ready_d = (state_d == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         shadow_q     <= '0;
         last_q       <= '0;
         mode_q       <= 1'b0;
         x_q          <= 1'b0;
         x_valid_q    <= 1'b0;
         sof_q        <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         shadow_q     <= shadow_d;
         last_q       <= last_d;
         mode_q       <= mode_d;
         x_q          <= x_d;
         x_valid_q    <= x_valid_d;
         sof_q        <= sof_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign load_ready = load_ready_q;
   assign x          = x_q;
   assign x_valid    = x_valid_q;
   assign sof        = sof_q;
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_source.sv
`default_nettype none
// ============================================================================
// tb_serial_pattern_source : randomized bench with stream model and 1011 detector
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_serial_pattern_source;

   localparam int WIDTH = 24;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_data = '0;
   logic [LEN_W-1:0] load_len = '0;
   logic             mode = 1'b0;
   logic             stop = 1'b0;
   logic             load_ready;
   logic             x;
   logic             x_valid;
   logic             sof;
   logic             done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_pattern_source #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .mode       (mode),
      .stop       (stop),
      .x          (x),
      .x_valid    (x_valid),
      .sof        (sof),
      .done       (done)
   );

   // Downstream sequence detector (overlapping "1011"), fed by the serial stream.
   logic [1:0] det_st;
   logic       z;
   always @(posedge clk) begin
      if (!rst) begin
         det_st <= 2'd0;
         z      <= 1'b0;
      end else if (x_valid) begin
         case (det_st)
            2'd0: det_st <= x ? 2'd1 : 2'd0;
            2'd1: det_st <= x ? 2'd1 : 2'd2;
            2'd2: det_st <= x ? 2'd3 : 2'd0;
            2'd3: det_st <= x ? 2'd1 : 2'd2;
         endcase
         z <= (det_st == 2'd3) && x;
      end else begin
         z <= 1'b0;
      end
   end

   // Reference for z: last four valid bits of the stream equal 1011.
   logic       rst_smp;
   logic       mon_en = 1'b0;
   logic       pend_v = 1'b0;
   logic       pend_x = 1'b0;
   logic [3:0] hist   = 4'b0;
   logic       exp_z  = 1'b0;
   always @(posedge clk) rst_smp <= rst;
   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_smp) begin
            hist  = 4'b0;
            exp_z = 1'b0;
         end else if (pend_v) begin
            hist  = {hist[2:0], pend_x};
            exp_z = (hist == 4'b1011);
         end else begin
            exp_z = 1'b0;
         end
         checks++;
         if (z !== exp_z) begin
            failures++;
            $display("FAIL detector_z t=%0t got=%b exp=%b", $time, z, exp_z);
         end
      end
      pend_v = x_valid;
      pend_x = x;
   end

   function automatic int model_len(input int len);
      return ((len == 0) || (len > WIDTH)) ? WIDTH : len;
   endfunction

   // k-th bit of a stream that cycles through the top len bits of pat, MSB first.
   function automatic logic model_bit(input logic [WIDTH-1:0] pat, input int len, input int k);
      int idx;
      idx = k % len;
      return pat[WIDTH-1-idx];
   endfunction

   task automatic test_reset();
      rst        = 1'b0;
      load_valid = 1'b1;
      load_data  = 24'hFFFFFF;
      repeat (3) @(negedge clk);
      checks++;
      if ({x_valid, x, sof, done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {x_valid, x, sof, done});
      end
      rst        = 1'b1;
      load_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({load_ready, x_valid, x, sof, done} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_release got=%b exp=10000", {load_ready, x_valid, x, sof, done});
      end
   endtask

   task automatic test_oneshot();
      logic [WIDTH-1:0] pat;
      int               len;
      int               n;
      logic [3:0]       exp;
      for (int t = 0; t < 6; t++) begin
         if (t == 0) begin
            pat = 24'hC90940;
            len = 24;
         end else begin
            pat = WIDTH'($urandom);
            len = (t == 1) ? 1 : int'($urandom_range(1, WIDTH));
         end
         n = model_len(len);
         checks++;
         if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_ready t=%0d got=%b exp=1", t, load_ready);
         end
         load_valid = 1'b1;
         load_data  = pat;
         load_len   = LEN_W'(len);
         mode       = 1'b0;
         @(negedge clk);
         load_valid = 1'b0;
         load_data  = WIDTH'($urandom);
         load_len   = LEN_W'($urandom);
         mode       = 1'($urandom);
         for (int k = 0; k < n; k++) begin
            exp = {1'b1, model_bit(pat, n, k), (k == 0), 1'b0};
            checks++;
            if ({x_valid, x, sof, done} !== exp) begin
               failures++;
               $display("FAIL oneshot_bit t=%0d k=%0d got=%b exp=%b", t, k, {x_valid, x, sof, done}, exp);
            end
            @(negedge clk);
         end
         checks++;
         if ({load_ready, x_valid, x, sof, done} !== 5'b00001) begin
            failures++;
            $display("FAIL oneshot_done t=%0d got=%b exp=00001", t, {load_ready, x_valid, x, sof, done});
         end
         @(negedge clk);
         checks++;
         if ({load_ready, x_valid, x, sof, done} !== 5'b10000) begin
            failures++;
            $display("FAIL oneshot_idle t=%0d got=%b exp=10000", t, {load_ready, x_valid, x, sof, done});
         end
      end
   endtask

   task automatic test_len_bounds();
      int lens[3] = '{0, 31, 25};
      for (int t = 0; t < 3; t++) begin
         load_valid = 1'b1;
         load_data  = 24'hFFFFFF;
         load_len   = LEN_W'(lens[t]);
         mode       = 1'b0;
         @(negedge clk);
         load_valid = 1'b0;
         for (int k = 0; k < WIDTH; k++) begin
            checks++;
            if ({x_valid, x, done} !== 3'b110) begin
               failures++;
               $display("FAIL lenbound_bit len=%0d k=%0d got=%b exp=110", lens[t], k, {x_valid, x, done});
            end
            @(negedge clk);
         end
         checks++;
         if ({x_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL lenbound_done len=%0d got=%b exp=01", lens[t], {x_valid, done});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rotate();
      logic [WIDTH-1:0] pat;
      int               n;
      int               cyc;
      logic [3:0]       exp;
      for (int t = 0; t < 3; t++) begin
         pat = (t == 0) ? 24'hA50000 : WIDTH'($urandom);
         n   = (t == 0) ? 8 : int'($urandom_range(1, WIDTH));
         cyc = 3 * n + 5;
         load_valid = 1'b1;
         load_data  = pat;
         load_len   = LEN_W'(n);
         mode       = 1'b1;
         @(negedge clk);
         load_valid = 1'b0;
         mode       = 1'b0;
         load_data  = WIDTH'($urandom);
         for (int k = 0; k < cyc; k++) begin
            exp = {1'b1, model_bit(pat, n, k), ((k % n) == 0), 1'b0};
            checks++;
            if ({x_valid, x, sof, done} !== exp) begin
               failures++;
               $display("FAIL rotate_bit t=%0d k=%0d got=%b exp=%b", t, k, {x_valid, x, sof, done}, exp);
            end
            if (k == cyc - 1) stop = 1'b1;
            @(negedge clk);
         end
         stop = 1'b0;
         checks++;
         if ({load_ready, x_valid, x, sof, done} !== 5'b00001) begin
            failures++;
            $display("FAIL rotate_stop t=%0d got=%b exp=00001", t, {load_ready, x_valid, x, sof, done});
         end
         @(negedge clk);
         checks++;
         if ({load_ready, x_valid, done} !== 3'b100) begin
            failures++;
            $display("FAIL rotate_idle t=%0d got=%b exp=100", t, {load_ready, x_valid, done});
         end
      end
   endtask

   task automatic test_stop();
      logic [WIDTH-1:0] pat;
      int               n;
      logic [4:0]       first5;
      // Abort during the fifth bit of a rotating stream.
      first5     = 5'b11110;
      load_valid = 1'b1;
      load_data  = 24'hF00000;
      load_len   = LEN_W'(8);
      mode       = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({x_valid, x, done} !== {1'b1, first5[4-k], 1'b0}) begin
            failures++;
            $display("FAIL stop5_bit k=%0d got=%b exp=%b", k, {x_valid, x, done}, {1'b1, first5[4-k], 1'b0});
         end
         if (k == 4) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      checks++;
      if ({load_ready, x_valid, x, sof, done} !== 5'b00001) begin
         failures++;
         $display("FAIL stop5_done got=%b exp=00001", {load_ready, x_valid, x, sof, done});
      end
      @(negedge clk);
      checks++;
      if ({load_ready, x_valid, done} !== 3'b100) begin
         failures++;
         $display("FAIL stop5_idle got=%b exp=100", {load_ready, x_valid, done});
      end
      // Abort coinciding with the final bit of a one-shot: still a single done.
      pat        = WIDTH'($urandom);
      n          = int'($urandom_range(2, WIDTH));
      load_valid = 1'b1;
      load_data  = pat;
      load_len   = LEN_W'(n);
      mode       = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         checks++;
         if ({x_valid, x} !== {1'b1, model_bit(pat, n, k)}) begin
            failures++;
            $display("FAIL stoplast_bit k=%0d got=%b exp=%b", k, {x_valid, x}, {1'b1, model_bit(pat, n, k)});
         end
         if (k == n - 1) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      checks++;
      if ({x_valid, done} !== 2'b01) begin
         failures++;
         $display("FAIL stoplast_done got=%b exp=01", {x_valid, done});
      end
      @(negedge clk);
      checks++;
      if ({load_ready, x_valid, done} !== 3'b100) begin
         failures++;
         $display("FAIL stoplast_idle got=%b exp=100", {load_ready, x_valid, done});
      end
      // Stop while idle is ignored; a load offered with stop high is accepted.
      stop = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if ({load_ready, x_valid, done} !== 3'b100) begin
            failures++;
            $display("FAIL stopidle k=%0d got=%b exp=100", k, {load_ready, x_valid, done});
         end
      end
      pat        = WIDTH'($urandom);
      load_valid = 1'b1;
      load_data  = pat;
      load_len   = LEN_W'(4);
      mode       = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      stop       = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({x_valid, x, sof} !== {1'b1, model_bit(pat, 4, k), (k == 0)}) begin
            failures++;
            $display("FAIL stopload_bit k=%0d got=%b exp=%b", k, {x_valid, x, sof}, {1'b1, model_bit(pat, 4, k), (k == 0)});
         end
         @(negedge clk);
      end
      checks++;
      if ({x_valid, done} !== 2'b01) begin
         failures++;
         $display("FAIL stopload_done got=%b exp=01", {x_valid, done});
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_load();
      logic [WIDTH-1:0] pat;
      pat        = WIDTH'($urandom);
      load_valid = 1'b1;
      load_data  = pat;
      load_len   = LEN_W'(0);
      mode       = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         checks++;
         if ({x_valid, x, sof, done} !== {1'b1, model_bit(pat, WIDTH, k), (k == 0), 1'b0}) begin
            failures++;
            $display("FAIL ignore_bit k=%0d got=%b exp=%b", k, {x_valid, x, sof, done},
                     {1'b1, model_bit(pat, WIDTH, k), (k == 0), 1'b0});
         end
         load_valid = (k == 5) || (k == 6);
         load_data  = 24'h000001;
         load_len   = LEN_W'(1);
         mode       = 1'b1;
         @(negedge clk);
      end
      load_valid = 1'b0;
      checks++;
      if ({x_valid, done} !== 2'b01) begin
         failures++;
         $display("FAIL ignore_done got=%b exp=01", {x_valid, done});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] pat;
      pat        = WIDTH'($urandom);
      load_valid = 1'b1;
      load_data  = pat;
      load_len   = LEN_W'(24);
      mode       = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if ({x_valid, x} !== {1'b1, model_bit(pat, WIDTH, k)}) begin
            failures++;
            $display("FAIL rstmid_bit k=%0d got=%b exp=%b", k, {x_valid, x}, {1'b1, model_bit(pat, WIDTH, k)});
         end
         if (k == 9) rst = 1'b0;
         @(negedge clk);
      end
      checks++;
      if ({x_valid, x, sof, done} !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_outputs got=%b exp=0000", {x_valid, x, sof, done});
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({load_ready, x_valid, done} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_after k=%0d got=%b exp=100", k, {load_ready, x_valid, done});
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_oneshot();
      test_len_bounds();
      test_rotate();
      test_stop();
      test_ignore_load();
      test_reset_mid();
      test_oneshot();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
